button_event_arbiter: RTL and testbench
=======================================

Name: button_event_arbiter

Overview:
- Collects one-cycle edge pulses (rising and falling) from N_CH per-button debouncers.
- Latches each pulse as a pending event and hands events one at a time to a single consumer, such as the control FSM or an event FIFO, over a valid/ready interface.
- Channels are served round-robin. Events that arrive while the same event is still pending are coalesced, and the loss is flagged by a sticky overrun bit.

Parameters:
- N_CH, default 4: number of button channels (2..16).
- CH_BIT, default $clog2(N_CH): width of the channel index (derived, not overridden).

Ports:
- i_clk  input  1  system clock, all logic on posedge.
- i_rst  input  1  synchronous, active-high reset.
- i_pos  input  N_CH  per-channel rising-edge pulse (debounced), one cycle wide.
- i_neg  input  N_CH  per-channel falling-edge pulse (debounced), one cycle wide.
- i_ready  input  1  consumer accepts the presented event this cycle.
- i_clr_overrun  input  1  clears all o_overrun bits.
- o_valid  output  1  event presented.
- o_ch  output  CH_BIT  channel of the presented event.
- o_edge  output  1  1 = rising, 0 = falling.
- o_overrun  output  N_CH  sticky per-channel event-lost flag.
- o_busy  output  1  any event pending or presented.

Behaviour:
- Reset (i_rst high at a posedge):
  - o_valid, o_ch, o_edge, o_overrun, o_busy, and all pending and age bits go to 0.
  - The round-robin pointer last_grant goes to N_CH-1, so channel 0 has first priority.
  - Reset overrides every other input, including mid-presentation; a presented event is discarded.
- Pending latch, per channel k:
  - pend_pos[k] is set by i_pos[k]; pend_neg[k] is set by i_neg[k].
  - Both are set if i_pos[k] and i_neg[k] arrive in the same cycle.
  - A pending bit clears only on acceptance (o_valid & i_ready) of that exact event.
- Age bit neg_first[k] (1 = the falling event is older):
  - Written when a pend bit is set while the other pend bit is already 1.
  - On a simultaneous set of both bits, rising is older.
- Coalescing and overrun:
  - If a pulse arrives for a pend bit that is already 1 and not being accepted that cycle, the pulse is dropped and o_overrun[k] is set.
  - If the pulse arrives in the same cycle that bit is accepted, the bit stays set (new event) and there is no overrun.
  - If i_clr_overrun and a new overrun occur in the same cycle, the overrun wins (the bit stays 1).
- FSM with two states, IDLE and PRESENT:
  - IDLE: if any pend bit is 1, select the first channel with a pending event, searching from last_grant+1 with wrap modulo N_CH.
    - If only one edge is pending on that channel, present it; if both are pending, present the older (per neg_first).
    - Register o_ch and o_edge, set o_valid=1, update last_grant to the selected channel, and go to PRESENT.
    - Otherwise stay in IDLE with o_valid=0.
  - PRESENT: o_valid, o_ch and o_edge hold stable while i_ready=0, regardless of new pulses.
    - On i_ready=1, clear the presented pend bit, drop o_valid, and go to IDLE.
- Latency and throughput:
  - A pulse sampled at edge t sets pend at t; the IDLE selection at edge t+1 gives o_valid high after t+1 (two edges from pulse to valid when idle).
  - Throughput is at most 1 event per 2 cycles (one IDLE bubble after each accept).
- i_ready while o_valid=0 is ignored.
- o_busy = OR of all pend bits | o_valid (combinational from registers).
- Index arithmetic is done CH_BIT+1 wide with an explicit modulo N_CH wrap, so that non-power-of-2 N_CH is handled correctly.

Test Plan:
- Reset and single event:
  - Stimulus: assert i_rst, then i_pos[2] for 1 cycle, with i_ready=1.
  - Required: o_valid high for exactly 1 cycle, 2 edges after the pulse, with o_ch=2 and o_edge=1; o_busy returns to 0.
- Round-robin:
  - Stimulus: i_neg[0], i_neg[1] and i_neg[3] in the same cycle, with i_ready=1.
  - Required: grants in the order ch0, ch1, ch3, each with o_edge=0, spaced 2 cycles apart.
  - Follow-up: a new i_pos[0] pulse after these grants; then i_pos[1] and i_pos[3] together. Required: the next grant is ch1, per the pointer.
- Backpressure:
  - Stimulus: present an event on ch1 and hold i_ready=0 for 10 cycles while pulsing i_pos[3].
  - Required: o_ch=1 stays stable throughout; after i_ready, ch3 rising is presented next.
- Ordering and overrun:
  - Stimulus: on ch0, i_neg, then 2 cycles later i_pos, then i_pos again, all with i_ready=0.
  - Required: o_overrun[0]=1.
  - Stimulus: then i_ready=1. Required: the falling event is delivered before the rising event; exactly 2 events are delivered.
  - Stimulus: i_clr_overrun. Required: o_overrun[0]=0.
- Accept and pulse collision:
  - Stimulus: i_pos[2] arrives in the same cycle its pending rising event is accepted.
  - Required: no overrun, and a second ch2 rising event is presented afterward.
- Reset mid-operation:
  - Stimulus: assert i_rst while o_valid=1 and 3 channels are pending.
  - Required: all outputs are 0 the next cycle; no stale event is presented after reset is released.

Source files
------------

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter turning debounced button edge pulses into a single
// valid/ready event stream, with coalescing and sticky per-channel overrun.
module button_event_arbiter #(
    parameter int  N_CH   = 4,
    localparam int CH_BIT = $clog2(N_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_CH-1:0]   i_pos,
    input  logic [N_CH-1:0]   i_neg,
    input  logic              i_ready,
    input  logic              i_clr_overrun,
    output logic              o_valid,
    output logic [CH_BIT-1:0] o_ch,
    output logic              o_edge,
    output logic [N_CH-1:0]   o_overrun,
    output logic              o_busy
);

    localparam int IW = CH_BIT + 1;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t state;
    state_t state_n;

    logic [N_CH-1:0]   pend_pos;
    logic [N_CH-1:0]   pend_neg;
    logic [N_CH-1:0]   neg_first;
    logic [N_CH-1:0]   pend_pos_n;
    logic [N_CH-1:0]   pend_neg_n;
    logic [N_CH-1:0]   neg_first_n;
    logic [N_CH-1:0]   overrun_n;
    logic [N_CH-1:0]   ch_hot;
    logic [N_CH-1:0]   acc_pos;
    logic [N_CH-1:0]   acc_neg;
    logic [N_CH-1:0]   pos_keep;
    logic [N_CH-1:0]   neg_keep;
    logic [N_CH-1:0]   pos_new;
    logic [N_CH-1:0]   neg_new;
    logic [CH_BIT-1:0] last_grant;
    logic [CH_BIT-1:0] last_grant_n;
    logic [CH_BIT-1:0] ch_n;
    logic [CH_BIT-1:0] sel_ch;
    logic [IW-1:0]     idx;
    logic              edge_n;
    logic              sel_edge;
    logic              sel_found;
    logic              accept;

    assign o_valid = (state == PRESENT);
    assign o_busy  = (|pend_pos) | (|pend_neg) | o_valid;
    assign accept  = o_valid & i_ready;

    // One-hot of the pend bit being retired by this cycle's handshake
    assign ch_hot  = accept ? (N_CH'(1) << o_ch) : '0;
    assign acc_pos = o_edge ? ch_hot : '0;
    assign acc_neg = o_edge ? '0 : ch_hot;

    assign pos_keep   = pend_pos & ~acc_pos;
    assign neg_keep   = pend_neg & ~acc_neg;
    assign pos_new    = i_pos & ~pos_keep;
    assign neg_new    = i_neg & ~neg_keep;
    assign pend_pos_n = pos_keep | i_pos;
    assign pend_neg_n = neg_keep | i_neg;

    // A new overrun in the same cycle as a clear still leaves the bit set
    assign overrun_n = (i_clr_overrun ? '0 : o_overrun)
                     | (i_pos & pos_keep)
                     | (i_neg & neg_keep);

    always_comb begin
        neg_first_n = neg_first;
        for (int k = 0; k < N_CH; k++) begin
            if (pos_new[k] && neg_new[k]) begin
                neg_first_n[k] = 1'b0;
            end else if (pos_new[k] && neg_keep[k]) begin
                neg_first_n[k] = 1'b1;
            end else if (neg_new[k] && pos_keep[k]) begin
                neg_first_n[k] = 1'b0;
            end
        end
    end

    // Wrap is explicit so non-power-of-two channel counts stay in range
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        sel_edge  = 1'b0;
        idx       = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = {1'b0, last_grant} + IW'(i);
            if (idx >= IW'(N_CH)) begin
                idx = idx - IW'(N_CH);
            end
            if (!sel_found
                && (pend_pos[idx[CH_BIT-1:0]] || pend_neg[idx[CH_BIT-1:0]])) begin
                sel_found = 1'b1;
                sel_ch    = idx[CH_BIT-1:0];
                if (pend_neg[idx[CH_BIT-1:0]]) begin
                    sel_edge = pend_pos[idx[CH_BIT-1:0]]
                             & ~neg_first[idx[CH_BIT-1:0]];
                end else begin
                    sel_edge = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n      = state;
        ch_n         = o_ch;
        edge_n       = o_edge;
        last_grant_n = last_grant;
        unique case (state)
            IDLE: begin
                if (sel_found) begin
                    state_n      = PRESENT;
                    ch_n         = sel_ch;
                    edge_n       = sel_edge;
                    last_grant_n = sel_ch;
                end
            end
            PRESENT: begin
                if (i_ready) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            o_ch       <= '0;
            o_edge     <= 1'b0;
            last_grant <= CH_BIT'(N_CH - 1);
            pend_pos   <= '0;
            pend_neg   <= '0;
            neg_first  <= '0;
            o_overrun  <= '0;
        end else begin
            state      <= state_n;
            o_ch       <= ch_n;
            o_edge     <= edge_n;
            last_grant <= last_grant_n;
            pend_pos   <= pend_pos_n;
            pend_neg   <= pend_neg_n;
            neg_first  <= neg_first_n;
            o_overrun  <= overrun_n;
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: directed scenarios plus random traffic,
// all cycles compared against a per-channel event-queue reference model.
module tb_button_event_arbiter;

    localparam int N  = 4;
    localparam int CB = $clog2(N);

    logic          clk = 1'b0;
    logic          i_rst = 1'b0;
    logic [N-1:0]  i_pos = '0;
    logic [N-1:0]  i_neg = '0;
    logic          i_ready = 1'b0;
    logic          i_clr_overrun = 1'b0;
    logic          o_valid;
    logic [CB-1:0] o_ch;
    logic          o_edge;
    logic [N-1:0]  o_overrun;
    logic          o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each channel keeps its pending edges oldest-first
    int           q[N][$];
    logic [N-1:0] m_ovr = '0;
    bit           m_valid = 1'b0;
    int           m_ch = 0;
    int           m_edge = 0;
    int           m_lg = N - 1;

    button_event_arbiter #(.N_CH(N)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_pos         (i_pos),
        .i_neg         (i_neg),
        .i_ready       (i_ready),
        .i_clr_overrun (i_clr_overrun),
        .o_valid       (o_valid),
        .o_ch          (o_ch),
        .o_edge        (o_edge),
        .o_overrun     (o_overrun),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_add(input int c, input int e);
        bit hit = 1'b0;
        foreach (q[c][j]) if (q[c][j] == e) hit = 1'b1;
        if (hit) m_ovr[c] = 1'b1;
        else q[c].push_back(e);
    endtask

    task automatic m_remove(input int c, input int e);
        for (int j = 0; j < q[c].size(); j++) begin
            if (q[c][j] == e) begin
                q[c].delete(j);
                break;
            end
        end
    endtask

    function automatic bit m_busy();
        bit b = m_valid;
        for (int c = 0; c < N; c++) if (q[c].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic tick(input logic r, input logic [N-1:0] p,
                        input logic [N-1:0] n, input logic rd,
                        input logic cl);
        bit found = 1'b0;
        int sel = 0;
        int sel_e = 0;
        i_rst = r;
        i_pos = p;
        i_neg = n;
        i_ready = rd;
        i_clr_overrun = cl;
        if (r) begin
            for (int c = 0; c < N; c++) q[c].delete();
            m_ovr = '0;
            m_valid = 1'b0;
            m_ch = 0;
            m_edge = 0;
            m_lg = N - 1;
        end else begin
            if (!m_valid) begin
                for (int i = 1; i <= N; i++) begin
                    int c = (m_lg + i) % N;
                    if (!found && q[c].size() > 0) begin
                        found = 1'b1;
                        sel = c;
                        sel_e = q[c][0];
                    end
                end
            end
            if (m_valid && rd) m_remove(m_ch, m_edge);
            if (cl) m_ovr = '0;
            for (int c = 0; c < N; c++) begin
                if (p[c]) m_add(c, 1);
                if (n[c]) m_add(c, 0);
            end
            if (m_valid) begin
                if (rd) m_valid = 1'b0;
            end else if (found) begin
                m_valid = 1'b1;
                m_ch = sel;
                m_edge = sel_e;
                m_lg = sel;
            end
        end
        @(posedge clk);
        #1;
        check("m_valid", 32'(o_valid), 32'(m_valid));
        check("m_busy", 32'(o_busy), 32'(m_busy()));
        check("m_overrun", 32'(o_overrun), 32'(m_ovr));
        if (m_valid) begin
            check("m_ch", 32'(o_ch), 32'(m_ch));
            check("m_edge", 32'(o_edge), 32'(m_edge));
        end
    endtask

    initial begin
        int gch[4];
        int gcy[4];
        int ge[4];
        int ng;
        logic [N-1:0] rp;
        logic [N-1:0] rn;

        // Reset and single event
        tick(1, '0, '0, 0, 0);
        tick(1, '0, '0, 0, 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_ovr", 32'(o_overrun), 0);
        tick(0, 4'b0100, '0, 1, 0);
        check("single_lat1", 32'(o_valid), 0);
        tick(0, '0, '0, 1, 0);
        check("single_valid", 32'(o_valid), 1);
        check("single_ch", 32'(o_ch), 2);
        check("single_edge", 32'(o_edge), 1);
        tick(0, '0, '0, 1, 0);
        check("single_drop", 32'(o_valid), 0);
        check("single_busy", 32'(o_busy), 0);

        // Round-robin from a fresh pointer
        tick(1, '0, '0, 0, 0);
        tick(0, '0, 4'b1011, 1, 0);
        ng = 0;
        for (int i = 0; i < 4; i++) begin
            gch[i] = -1;
            gcy[i] = -1;
            ge[i] = -1;
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, '0, '0, 1, 0);
            if (o_valid && ng < 4) begin
                gch[ng] = int'(o_ch);
                ge[ng] = int'(o_edge);
                gcy[ng] = i;
                ng++;
            end
        end
        check("rr_count", 32'(ng), 3);
        check("rr_g0", 32'(gch[0]), 0);
        check("rr_g1", 32'(gch[1]), 1);
        check("rr_g2", 32'(gch[2]), 3);
        check("rr_edges", 32'(ge[0] | ge[1] | ge[2]), 0);
        check("rr_space1", 32'(gcy[1] - gcy[0]), 2);
        check("rr_space2", 32'(gcy[2] - gcy[1]), 2);
        tick(0, 4'b0001, '0, 1, 0);
        tick(0, '0, '0, 1, 0);
        check("rr_pos0", 32'(o_ch), 0);
        tick(0, '0, '0, 1, 0);
        tick(0, 4'b1010, '0, 1, 0);
        tick(0, '0, '0, 1, 0);
        check("rr_ptr_valid", 32'(o_valid), 1);
        check("rr_ptr_ch", 32'(o_ch), 1);
        tick(0, '0, '0, 1, 0);
        tick(0, '0, '0, 1, 0);
        check("rr_ptr_next", 32'(o_ch), 3);
        tick(0, '0, '0, 1, 0);

        // Backpressure
        tick(0, 4'b0010, '0, 0, 0);
        tick(0, '0, '0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(0, (i == 3) ? 4'b1000 : 4'b0000, '0, 0, 0);
            check("bp_valid", 32'(o_valid), 1);
            check("bp_ch", 32'(o_ch), 1);
        end
        tick(0, '0, '0, 1, 0);
        tick(0, '0, '0, 1, 0);
        check("bp_next_ch", 32'(o_ch), 3);
        check("bp_next_edge", 32'(o_edge), 1);
        tick(0, '0, '0, 1, 0);

        // Ordering and overrun on channel 0
        tick(0, '0, 4'b0001, 0, 0);
        tick(0, '0, '0, 0, 0);
        tick(0, 4'b0001, '0, 0, 0);
        tick(0, 4'b0001, '0, 0, 0);
        check("ovr_set", 32'(o_overrun[0]), 1);
        ng = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_valid && ng < 4) begin
                gch[ng] = int'(o_ch);
                ge[ng] = int'(o_edge);
                ng++;
            end
            tick(0, '0, '0, 1, 0);
        end
        check("ord_count", 32'(ng), 2);
        check("ord_first", 32'(ge[0]), 0);
        check("ord_second", 32'(ge[1]), 1);
        check("ord_ch", 32'(gch[0] | gch[1]), 0);
        tick(0, '0, '0, 1, 1);
        check("ovr_clr", 32'(o_overrun[0]), 0);

        // Pulse colliding with acceptance of the same event
        tick(0, 4'b0100, '0, 0, 0);
        tick(0, '0, '0, 0, 0);
        tick(0, 4'b0100, '0, 1, 0);
        check("coll_ovr", 32'(o_overrun[2]), 0);
        check("coll_busy", 32'(o_busy), 1);
        tick(0, '0, '0, 0, 0);
        check("coll_valid", 32'(o_valid), 1);
        check("coll_ch", 32'(o_ch), 2);
        check("coll_edge", 32'(o_edge), 1);
        tick(0, '0, '0, 1, 0);

        // Reset in the middle of a presentation
        tick(0, 4'b1011, '0, 0, 0);
        tick(0, '0, '0, 0, 0);
        check("mid_valid_pre", 32'(o_valid), 1);
        tick(1, '0, '0, 0, 0);
        check("mid_valid", 32'(o_valid), 0);
        check("mid_ch", 32'(o_ch), 0);
        check("mid_edge", 32'(o_edge), 0);
        check("mid_ovr", 32'(o_overrun), 0);
        check("mid_busy", 32'(o_busy), 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, '0, '0, 1, 0);
            check("mid_stale", 32'(o_valid), 0);
        end

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            rp = N'($urandom & $urandom & $urandom);
            rn = N'($urandom & $urandom & $urandom);
            tick(($urandom_range(0, 199) == 0), rp, rn,
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
